// File: rtl/simon_pkg.sv
// Shared display codes, FSM encoding and button helpers for the Simon Says game controller.
package simon_pkg;

    localparam logic [2:0] RED       = 3'b000;
    localparam logic [2:0] GREEN     = 3'b001;
    localparam logic [2:0] BLUE      = 3'b010;
    localparam logic [2:0] YELLOW    = 3'b011;
    localparam logic [2:0] NEUTRAL   = 3'b100;
    localparam logic [2:0] LOSE_CODE = 3'b101;
    localparam logic [2:0] WIN_CODE  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD_STEP,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_WAIT_INPUT,
        ST_WIN,
        ST_LOSE
    } state_t;

    function automatic logic is_single(input logic [3:0] btn);
        return (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [1:0] btn_to_colour(input logic [3:0] btn);
        logic [1:0] colour;
        colour = 2'd0;
        if (btn[1]) colour = 2'd1;
        if (btn[2]) colour = 2'd2;
        if (btn[3]) colour = 2'd3;
        return colour;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the colour source.
module simon_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       i_rst_n,
    output logic [7:0] o_state
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game controller: grows a random colour sequence, plays it back on the
// display code and checks the player's presses against it.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int         MAX_LEVEL     = 16,
    parameter int         STEP_TICKS    = 50_000_000,
    parameter int         GAP_TICKS     = 12_500_000,
    parameter int         TIMEOUT_TICKS = 250_000_000,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [3:0] btn_i,
    output logic       ready_o,
    output logic [2:0] mensaje,
    output logic [4:0] level_o,
    output logic       win_o,
    output logic       lose_o
);

    localparam int MAX_A     = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
    localparam int CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [4:0]       LEVEL_MAX    = 5'(MAX_LEVEL);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_idx;
    logic [4:0]       r_level;
    logic [2:0]       r_mensaje;
    logic             r_ready;
    logic             r_win;
    logic             r_lose;
    logic             r_start_q;
    logic [3:0]       r_btn_q;
    logic [1:0]       r_seq [MAX_LEVEL];

    logic [7:0] w_lfsr;
    logic       w_unused_lfsr;
    logic       w_start_edge;
    logic       w_press;
    logic       w_single;
    logic [1:0] w_colour;
    logic [4:0] w_idx_inc;
    logic [1:0] w_seq_idx;
    logic [1:0] w_seq_next;

    simon_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .i_rst_n(reset),
        .o_state(w_lfsr)
    );

    // Only the two low LFSR bits pick a colour; the rest just keep the period long.
    assign w_unused_lfsr = ^w_lfsr[7:2];

    assign w_start_edge = start_i & ~r_start_q;
    assign w_press      = (|btn_i) & ~(|r_btn_q);
    assign w_single     = is_single(btn_i);
    assign w_colour     = btn_to_colour(btn_i);
    assign w_idx_inc    = r_idx + 5'd1;

    always_comb begin
        w_seq_idx  = 2'd0;
        w_seq_next = 2'd0;
        for (int i = 0; i < MAX_LEVEL; i++) begin
            if (r_idx == 5'(i))     w_seq_idx  = r_seq[i];
            if (w_idx_inc == 5'(i)) w_seq_next = r_seq[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_level   <= '0;
            r_mensaje <= NEUTRAL;
            r_ready   <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_start_q <= 1'b0;
            r_btn_q   <= '0;
            for (int i = 0; i < MAX_LEVEL; i++) r_seq[i] <= 2'd0;
        end else begin
            r_start_q <= start_i;
            r_btn_q   <= btn_i;
            if (w_start_edge) r_ready <= 1'b1;

            case (r_state)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (w_start_edge) begin
                        r_state   <= ST_ADD_STEP;
                        r_level   <= '0;
                        r_win     <= 1'b0;
                        r_lose    <= 1'b0;
                        r_mensaje <= NEUTRAL;
                    end
                end

                ST_ADD_STEP: begin
                    for (int i = 0; i < MAX_LEVEL; i++) begin
                        if (r_level == 5'(i)) r_seq[i] <= w_lfsr[1:0];
                    end
                    r_level <= r_level + 5'd1;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    // On the first step seq[0] is being written right now, so bypass it.
                    r_mensaje <= {1'b0, (r_level == 5'd0) ? w_lfsr[1:0] : r_seq[0]};
                    r_state   <= ST_SHOW_ON;
                end

                ST_SHOW_ON: begin
                    if (r_cnt == STEP_LAST) begin
                        r_cnt     <= '0;
                        r_mensaje <= NEUTRAL;
                        r_state   <= ST_SHOW_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_SHOW_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_idx_inc == r_level) begin
                            r_idx   <= '0;
                            r_state <= ST_WAIT_INPUT;
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_mensaje <= {1'b0, w_seq_next};
                            r_state   <= ST_SHOW_ON;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_WAIT_INPUT: begin
                    // A press in the expiry cycle is still honoured because it is tested first.
                    if (w_press) begin
                        if (!w_single || (w_colour != w_seq_idx)) begin
                            r_state   <= ST_LOSE;
                            r_lose    <= 1'b1;
                            r_mensaje <= LOSE_CODE;
                        end else begin
                            r_cnt     <= '0;
                            r_mensaje <= {1'b0, w_colour};
                            if (r_idx == r_level - 5'd1) begin
                                if (r_level == LEVEL_MAX) begin
                                    r_state   <= ST_WIN;
                                    r_win     <= 1'b1;
                                    r_mensaje <= WIN_CODE;
                                end else begin
                                    r_state <= ST_ADD_STEP;
                                end
                            end else begin
                                r_idx <= w_idx_inc;
                            end
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state   <= ST_LOSE;
                        r_lose    <= 1'b1;
                        r_mensaje <= LOSE_CODE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_mensaje <= NEUTRAL;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign mensaje = r_mensaje;
    assign level_o = r_level;
    assign win_o   = r_win;
    assign lose_o  = r_lose;

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer: an LFSR reference predicts each new step,
// expected display/level/status values are queued per cycle and compared as they appear.
module tb_simon_sequencer;
    import simon_pkg::*;

    localparam int MAXL = 3;
    localparam int STEP = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] btn_i = 4'd0;
    logic       ready_o;
    logic [2:0] mensaje;
    logic [4:0] level_o;
    logic       win_o;
    logic       lose_o;

    always #5 clk = ~clk;

    simon_sequencer #(
        .MAX_LEVEL    (MAXL),
        .STEP_TICKS   (STEP),
        .GAP_TICKS    (GAP),
        .TIMEOUT_TICKS(TMO),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start_i),
        .btn_i  (btn_i),
        .ready_o(ready_o),
        .mensaje(mensaje),
        .level_o(level_o),
        .win_o  (win_o),
        .lose_o (lose_o)
    );

    // Reference LFSR: Fibonacci, taps 8,6,5,4, seeded on reset, advancing every cycle.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct packed {
        logic [2:0] msg;
        logic [4:0] lvl;
        logic       win;
        logic       lose;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] exp_seq [MAXL];
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] m, input logic [4:0] l, input logic w, input logic lo);
        exp_t e;
        e.msg  = m;
        e.lvl  = l;
        e.win  = w;
        e.lose = lo;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " mensaje"}, 32'(mensaje), 32'(e.msg));
        chk({tag, " level"},   32'(level_o), 32'(e.lvl));
        chk({tag, " win"},     32'(win_o),   32'(e.win));
        chk({tag, " lose"},    32'(lose_o),  32'(e.lose));
    endtask

    task automatic start_game();
        start_i = 1'b1;
        push(NEUTRAL, 5'd0, 1'b0, 1'b0);
        tick();
        pop_cmp("start");
        chk("start ready", 32'(ready_o), 32'd1);
        start_i = 1'b0;
        $display("start game");
    endtask

    // Called while the DUT sits in ADD_STEP: the step being appended is the LFSR value now.
    task automatic play_round(input int lvl);
        exp_seq[lvl-1] = m_lfsr[1:0];
        for (int i = 0; i < lvl; i++) begin
            for (int k = 0; k < STEP; k++) push({1'b0, exp_seq[i]}, 5'(lvl), 1'b0, 1'b0);
            for (int k = 0; k < GAP; k++)  push(NEUTRAL, 5'(lvl), 1'b0, 1'b0);
        end
        push(NEUTRAL, 5'(lvl), 1'b0, 1'b0);
        while (sb.size() > 0) begin
            tick();
            pop_cmp("play");
        end
        $display("playback level=%0d done", lvl);
    endtask

    task automatic press(input logic [3:0] b, input logic [2:0] m, input logic [4:0] l,
                         input logic w, input logic lo, input string tag);
        btn_i = b;
        push(m, l, w, lo);
        tick();
        pop_cmp(tag);
        $display("press %s btn=%b mensaje=%b level=%0d win=%0b lose=%0b",
                 tag, b, mensaje, level_o, win_o, lose_o);
        btn_i = 4'd0;
    endtask

    initial begin
        logic [3:0] b;
        logic [1:0] wrong;
        logic [1:0] s;

        // Reset and idle
        reset = 1'b0;
        repeat (3) tick();
        push(NEUTRAL, 5'd0, 1'b0, 1'b0);
        pop_cmp("reset");
        chk("reset ready", 32'(ready_o), 32'd0);
        reset = 1'b1;
        repeat (100) tick();
        push(NEUTRAL, 5'd0, 1'b0, 1'b0);
        pop_cmp("idle");
        chk("idle ready", 32'(ready_o), 32'd0);

        // Full win
        start_game();
        for (int lvl = 1; lvl <= MAXL; lvl++) begin
            play_round(lvl);
            for (int i = 0; i < lvl; i++) begin
                b = 4'b0001 << exp_seq[i];
                if (i == lvl - 1 && lvl == MAXL) begin
                    press(b, WIN_CODE, 5'(lvl), 1'b1, 1'b0, "final");
                end else begin
                    press(b, {1'b0, exp_seq[i]}, 5'(lvl), 1'b0, 1'b0, "ok");
                    if (i != lvl - 1) tick();
                end
            end
        end
        push(WIN_CODE, 5'(MAXL), 1'b1, 1'b0);
        tick();
        pop_cmp("win hold");

        // Wrong press, then restart from LOSE
        start_game();
        play_round(1);
        wrong = exp_seq[0] + 2'd1;
        b = 4'b0001 << wrong;
        press(b, LOSE_CODE, 5'd1, 1'b0, 1'b1, "wrong");
        start_game();
        play_round(1);

        // Timeout boundary
        repeat (TMO - 1) tick();
        push(NEUTRAL, 5'd1, 1'b0, 1'b0);
        pop_cmp("pre timeout");
        push(LOSE_CODE, 5'd1, 1'b0, 1'b1);
        tick();
        pop_cmp("timeout");
        $display("timeout lose=%0b", lose_o);

        // Multi-button press
        start_game();
        play_round(1);
        press(4'b0011, LOSE_CODE, 5'd1, 1'b0, 1'b1, "multi");

        // Asynchronous reset during playback
        start_game();
        s = m_lfsr[1:0];
        push({1'b0, s}, 5'd1, 1'b0, 1'b0);
        tick();
        pop_cmp("show");
        tick();
        #2;
        reset = 1'b0;
        #1;
        push(NEUTRAL, 5'd0, 1'b0, 1'b0);
        pop_cmp("async reset");
        chk("async reset ready", 32'(ready_o), 32'd0);
        $display("async reset applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game-control stage of the Simon Says design, directly upstream of the LCD1604 controller.
- Generates a pseudo-random colour sequence, plays it out one step at a time on `mensaje`, then reads the player's buttons and compares them against the stored sequence.
- Drives `ready_o` (to the LCD `ready_i`), `mensaje` (to the LCD colour selector), plus level and win/lose status.
- Runs on the same system clock as the LCD controller. All timing is in `clk` cycles.

Parameters:
- MAX_LEVEL, 16, sequence length needed to win (max 31).
- STEP_TICKS, 50_000_000, cycles a colour stays on `mensaje` during playback.
- GAP_TICKS, 12_500_000, cycles of neutral code between playback steps.
- TIMEOUT_TICKS, 250_000_000, maximum cycles allowed between player presses.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  level; rising edge starts or restarts a game.
- btn_i  in  4  level, already synchronised and debounced; bit0=red, bit1=green, bit2=blue, bit3=yellow.
- ready_o  out  1  LCD enable-to-start.
- mensaje  out  3  display code.
- level_o  out  5  current sequence length.
- win_o  out  1  high while in WIN.
- lose_o  out  1  high while in LOSE.

Behaviour:
- Display codes:
  - 3'b000 red, 3'b001 green, 3'b010 blue, 3'b011 yellow.
  - 3'b100 neutral, 3'b101 lose, 3'b110 win.
  - The LCD maps codes 100–110 to its default text.
- Reset (`reset`=0, asynchronous) forces:
  - state=IDLE, `ready_o`=0, `mensaje`=3'b100, `level_o`=0, `win_o`=`lose_o`=0.
  - LFSR=LFSR_SEED, all counters=0.
  - Asserting reset mid-game aborts immediately; the sequence memory contents are don't-care.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every clock cycle regardless of state, so start timing seeds the randomness.
- Edge detection: registered copies of `start_i` and `btn_i`. A press = rising edge of the OR of `btn_i`. The press value is the `btn_i` bits sampled on that same edge cycle.
- `ready_o` sets on the first `start_i` edge and stays high until reset.
- All outputs are registered, one cycle after the state change.
- States and transitions:
  - IDLE: `mensaje`=100. On `start_i` edge -> ADD_STEP, with `level_o`=0.
  - ADD_STEP: `seq[level_o]` <= `lfsr[1:0]`; `level_o`++; idx=0 -> SHOW_ON. Takes 1 cycle.
  - SHOW_ON: `mensaje`={1'b0,`seq[idx]`} for STEP_TICKS cycles -> SHOW_GAP.
  - SHOW_GAP: `mensaje`=100 for GAP_TICKS cycles. Then idx++; if idx==`level_o` -> WAIT_INPUT with idx=0, timer=0; else -> SHOW_ON.
  - WAIT_INPUT:
    - On a press with exactly one bit set: `mensaje` = that colour code, compare it with `seq[idx]`.
    - Match and idx==`level_o`-1: -> WIN if `level_o`==MAX_LEVEL, else -> ADD_STEP.
    - Match otherwise: idx++, timer=0.
    - Mismatch, or a press with more than one bit set: -> LOSE.
    - Timer reaching TIMEOUT_TICKS-1 with no press: -> LOSE.
    - Presses in any other state are ignored.
  - WIN: `mensaje`=110, `win_o`=1. LOSE: `mensaje`=101, `lose_o`=1. Both hold until a `start_i` edge -> ADD_STEP with `level_o` reset to 0.
- Simultaneous events:
  - A `start_i` edge in any state other than IDLE/WIN/LOSE is ignored.
  - A press in the same cycle as timer expiry: the press wins.
- Width rules:
  - The tick counter is sized by $clog2 of the maximum of the three *_TICKS parameters.
  - idx and `level_o` are 5 bits; the sequence memory is MAX_LEVEL x 2 bits, held in registers.

Decomposition:
- Package `simon_pkg`: colour/display code localparams (RED..WIN_CODE) and the state encoding.
- Sub-module `simon_lfsr`: clock, async reset, seed parameter, 8-bit state output.
- The FSM, timers and sequence memory stay in `simon_sequencer`.

Test Plan:
All scenarios use STEP_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20, MAX_LEVEL=3.
- Reset then idle: `reset`=0 -> `mensaje`=100, `ready_o`=0, `level_o`=0. Release, no start for 100 cycles -> outputs unchanged.
- Playback timing: `start_i` pulse -> `ready_o`=1, `level_o`=1. `mensaje`=seq[0] for exactly 4 cycles, then 100 for 2 cycles, then WAIT_INPUT.
- Full win: bench mirrors `seq` via hierarchical read and presses the correct buttons each round. Expect `level_o` 1->2->3, then `win_o`=1 and `mensaje`=110.
- Wrong press: at level 1, press a colour ≠ seq[0] -> `lose_o`=1, `mensaje`=101 on the next cycle. A `start_i` edge then restarts with `level_o`=1.
- Timeout and multi-press:
  - No press for 20 cycles in WAIT_INPUT -> LOSE.
  - Separate run: `btn_i`=4'b0011 -> LOSE.
- Reset mid-playback: assert `reset` during SHOW_ON -> all outputs return to reset values asynchronously, without waiting for a clock edge.
